// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// Latency: n/a (wiring only).
// Backpressure: none; the requester holds off via stall_req while the unit is busy.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            stall_req;

    // Execute stage / hazard logic side
    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result, stall_req
    );

    // Multiply/divide unit side
    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result, stall_req
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply (radix-2 shift-add) and divide (restoring) unit.
// Latency: 34 cycles start-to-done, 1 cycle for divide-by-zero / signed overflow.
// Backpressure: holds stall_req from the start cycle until the cycle before done.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;

    state_t              state_q, state_d;
    logic [5:0]          cnt_q;
    // Upper half: partial product / partial remainder.
    // Lower half: multiplier being consumed / dividend becoming quotient.
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     opnd_q;     // multiplicand or divisor magnitude
    logic [2:0]          f3_q;
    logic                neg_q;      // sign of the selected result
    logic [XLEN-1:0]     result_q;

    // Operand decode at the start request
    logic                a_signed, b_signed, sign_a, sign_b, neg_in;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div_zero, div_ovf, fast_in, accept;
    logic [XLEN-1:0]     fast_val;

    // Iteration datapath
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       rem_sh, div_diff;
    logic [2*XLEN-1:0]   div_next;

    // Sign correction and result selection
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix, rem_fix, fix_val;

    // Decode signedness, magnitudes and the single-cycle divide corner cases
    always_comb begin
        a_signed = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU)
                   || (bus.funct3[2] && !bus.funct3[0]);
        b_signed = (bus.funct3 == F3_MULH) || (bus.funct3[2] && !bus.funct3[0]);
        sign_a   = a_signed && bus.op_a[XLEN-1];
        sign_b   = b_signed && bus.op_b[XLEN-1];
        mag_a    = sign_a ? -bus.op_a : bus.op_a;
        mag_b    = sign_b ? -bus.op_b : bus.op_b;
        // Remainder takes the dividend's sign; product and quotient the xor
        neg_in   = (bus.funct3[2] && bus.funct3[1]) ? sign_a : (sign_a ^ sign_b);
        div_zero = (bus.op_b == '0);
        div_ovf  = !bus.funct3[0]
                   && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.op_b == '1);
        fast_in  = bus.funct3[2] && (div_zero || div_ovf);
        fast_val = '0;
        if (div_zero)
            fast_val = bus.funct3[1] ? bus.op_a : '1;
        else
            fast_val = bus.funct3[1] ? '0 : bus.op_a;
        accept   = (state_q == S_IDLE) && bus.start && !bus.flush;
    end

    // One multiply or divide iteration on the accumulator
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        div_diff = rem_sh - {1'b0, opnd_q};
        if (div_diff[XLEN])
            div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    // Apply the latched sign and pick the architectural result
    always_comb begin
        prod_fix = (neg_q && acc_q != '0) ? -acc_q : acc_q;
        quot_fix = (neg_q && acc_q[XLEN-1:0] != '0) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = (neg_q && acc_q[2*XLEN-1:XLEN] != '0) ? -acc_q[2*XLEN-1:XLEN]
                                                          : acc_q[2*XLEN-1:XLEN];
        fix_val  = '0;
        case (f3_q)
            3'b000:                 fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quot_fix;
            default:                fix_val = rem_fix;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and status outputs; flush beats everything except reset
    always_comb begin
        state_d       = state_q;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.stall_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.stall_req = bus.start;
                if (accept)
                    state_d = fast_in ? S_DONE : S_CALC;
            end
            S_CALC: begin
                bus.busy      = 1'b1;
                bus.stall_req = 1'b1;
                if (bus.flush)
                    state_d = S_IDLE;
                else if (cnt_q == 6'(XLEN-1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                bus.busy      = 1'b1;
                bus.stall_req = 1'b1;
                state_d       = bus.flush ? S_IDLE : S_DONE;
            end
            default: begin
                bus.done = !bus.flush;
                state_d  = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        f3_q  <= bus.funct3;
                        neg_q <= neg_in;
                        cnt_q <= '0;
                        if (fast_in) begin
                            result_q <= fast_val;
                        end else begin
                            acc_q  <= {{XLEN{1'b0}}, bus.funct3[2] ? mag_a : mag_b};
                            opnd_q <= bus.funct3[2] ? mag_b : mag_a;
                        end
                    end
                end
                S_CALC: begin
                    if (!bus.flush) begin
                        acc_q <= f3_q[2] ? div_next : mul_next;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_FIX: begin
                    if (!bus.flush)
                        result_q <= fix_val;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, stall/busy/done, flush and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it to done (or through a flush).
    // flush_at > 0 pulses flush during that cycle; repulse re-presents start at cycles 5 and 20.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input int flush_at, input bit repulse);
        int lat;
        bit seen;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        #1;
        check({tag, ".stall_start"}, {31'd0, bus.stall_req}, 32'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = ~a;
        bus.op_b  = ~b;
        lat  = 1;
        seen = 1'b0;
        while (lat <= 40 && !seen) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (lat == 1 && exp_lat > 1)
                    check({tag, ".busy_c1"}, {31'd0, bus.busy}, 32'd1);
                if (flush_at > 0 && lat == flush_at + 1)
                    check({tag, ".idle_after_flush"}, {31'd0, bus.busy}, 32'd0);
                if (lat == flush_at)
                    bus.flush = 1'b1;
                if (repulse && (lat == 5 || lat == 20)) begin
                    bus.start  = 1'b1;
                    bus.funct3 = 3'b100;
                    bus.op_a   = 32'h0000_0055;
                    bus.op_b   = 32'h0000_0003;
                end
                @(posedge clk);
                #1;
                bus.flush = 1'b0;
                bus.start = 1'b0;
                lat++;
            end
        end
        if (flush_at > 0) begin
            check({tag, ".no_done"}, {31'd0, seen}, 32'd0);
            check({tag, ".result_kept"}, bus.result, exp_res);
        end else begin
            check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
            check({tag, ".result"}, bus.result, exp_res);
            check({tag, ".stall_at_done"}, {31'd0, bus.stall_req}, 32'd0);
            check({tag, ".busy_at_done"}, {31'd0, bus.busy}, 32'd0);
            @(posedge clk);
            #1;
            check({tag, ".done_pulse"}, {31'd0, bus.done}, 32'd0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.funct3 = 3'b000;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.flush  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy",   {31'd0, bus.busy},      32'd0);
        check("rst.done",   {31'd0, bus.done},      32'd0);
        check("rst.result", bus.result,             32'd0);
        check("rst.stall",  {31'd0, bus.stall_req}, 32'd0);
        rst = 1'b0;

        run_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 34, 32'hFFFF_FFEB, 0, 1'b0);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 0, 1'b0);
        run_op("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000, 34, 32'h4000_0000, 0, 1'b0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'd2,         34, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         34, 32'hFFFF_FFFD, 0, 1'b0);
        run_op("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         34, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("divu",   3'b101, 32'd100,        32'd7,         34, 32'd14,        0, 1'b0);
        run_op("remu",   3'b111, 32'd100,        32'd7,         34, 32'd2,         0, 1'b0);
        run_op("divu0",  3'b101, 32'd5,          32'd0,         1,  32'hFFFF_FFFF, 0, 1'b0);
        run_op("rem0",   3'b110, 32'd5,          32'd0,         1,  32'd5,         0, 1'b0);
        run_op("divovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 1,  32'h8000_0000, 0, 1'b0);

        // flush together with start in IDLE: not accepted
        @(negedge clk);
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        bus.funct3 = 3'b101;
        bus.op_a   = 32'd5;
        bus.op_b   = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start.done",   {31'd0, bus.done}, 32'd0);
        check("flush_start.busy",   {31'd0, bus.busy}, 32'd0);
        check("flush_start.result", bus.result,        32'h8000_0000);

        run_op("div_flush", 3'b100, 32'hFFFF_FFF9, 32'd2, 0, 32'h8000_0000, 10, 1'b0);
        run_op("mul_3x4",   3'b000, 32'd3,         32'd4, 34, 32'd12,       0,  1'b0);
        run_op("mul_repulse", 3'b000, 32'd7, 32'hFFFF_FFFD, 34, 32'hFFFF_FFEB, 0, 1'b1);

        // reset in the middle of a calculation
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.op_a   = 32'd9;
        bus.op_b   = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midcalc.busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.busy",   {31'd0, bus.busy},      32'd0);
        check("midrst.done",   {31'd0, bus.done},      32'd0);
        check("midrst.result", bus.result,             32'd0);
        check("midrst.stall",  {31'd0, bus.stall_req}, 32'd0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrst.no_done", {31'd0, bus.done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
